// File: rtl/lcd_bus_if.sv
// HD44780 4-bit character-LCD bus as seen between the display driver and its observers.
interface lcd_bus_if;
  logic sf_e;
  logic e;
  logic rs;
  logic rw;
  logic d;
  logic c;
  logic b;
  logic a;

  modport master (output sf_e, e, rs, rw, d, c, b, a);
  modport slave  (input  sf_e, e, rs, rw, d, c, b, a);
endinterface

// File: rtl/lcd_bus_decoder.sv
// Passive HD44780 4-bit bus decoder: rebuilds instruction/data bytes from strobed nibbles and
// keeps a 2x16 shadow of the visible DDRAM plus the display-control state.
module lcd_bus_decoder #(
  parameter int         MIN_E_HIGH = 12,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       clr_common,
  lcd_bus_if.slave   bus,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic       char_wr,
  output logic [4:0] char_idx,
  output logic [7:0] char_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic [6:0] ddram_addr,
  output logic       mode_4bit,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       incr,
  output logic       busy,
  output logic [2:0] err
);

  localparam int            CW      = $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_E_HIGH);

  typedef enum logic [1:0] {S_8BIT, S_HI, S_LO} state_t;

  // Strobe front end
  logic          e_prev_q;
  logic [CW-1:0] e_cnt_q;
  logic [3:0]    nib_q;
  logic          rs_s_q;
  logic          rw_s_q;
  logic          stb_q;
  logic          glitch_q;
  logic          ovr_q;

  // Decoder state
  state_t     state_q;
  logic [3:0] hi_nib_q;
  logic       hi_rs_q;
  logic [6:0] addr_q;
  logic       cgram_q;
  logic       mode_4bit_q;
  logic       disp_on_q;
  logic       cursor_on_q;
  logic       blink_on_q;
  logic       incr_q;
  logic       busy_q;
  logic [4:0] fill_idx_q;
  logic [2:0] err_q;
  logic       cmd_valid_q;
  logic [7:0] cmd_byte_q;
  logic       char_wr_q;
  logic [4:0] char_idx_q;
  logic [7:0] char_data_q;
  logic [7:0] rd_char_q;

  logic [7:0] shadow_mem [32];

  logic [7:0] byte_d;
  logic       lo_stb_d;
  logic       rs_bad_d;
  logic       exec_d;
  logic       in_ddram_d;
  logic [4:0] wr_idx_d;
  logic       data_wr_d;
  logic [6:0] addr_step_d;

  // Wrap points follow the panel's two-line DDRAM map (0x00-0x27, 0x40-0x67).
  function automatic logic [6:0] step_addr(input logic [6:0] cur, input logic up);
    logic [6:0] nxt;
    if (up) begin
      if (cur == 7'h27 || cur == 7'h3F)      nxt = 7'h40;
      else if (cur == 7'h67 || cur == 7'h7F) nxt = 7'h00;
      else                                   nxt = cur + 7'd1;
    end else begin
      if (cur == 7'h00)      nxt = 7'h67;
      else if (cur == 7'h40) nxt = 7'h27;
      else                   nxt = cur - 7'd1;
    end
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (clr_common) begin
      e_prev_q <= 1'b0;
      e_cnt_q  <= '0;
      nib_q    <= 4'h0;
      rs_s_q   <= 1'b0;
      rw_s_q   <= 1'b0;
      stb_q    <= 1'b0;
      glitch_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      stb_q    <= 1'b0;
      glitch_q <= 1'b0;
      ovr_q    <= 1'b0;
      if (!bus.sf_e) begin
        e_prev_q <= 1'b0;
        e_cnt_q  <= '0;
      end else begin
        e_prev_q <= bus.e;
        if (bus.e) begin
          if (e_cnt_q != CNT_MAX) e_cnt_q <= e_cnt_q + CW'(1);
          nib_q  <= {bus.d, bus.c, bus.b, bus.a};
          rs_s_q <= bus.rs;
          rw_s_q <= bus.rw;
        end else if (e_prev_q) begin
          e_cnt_q <= '0;
          // Read strobes are busy-flag polls from the driver and never disturb state.
          if (!rw_s_q) begin
            if (e_cnt_q != CNT_MAX) glitch_q <= 1'b1;
            else if (busy_q)        ovr_q    <= 1'b1;
            else                    stb_q    <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    byte_d      = {hi_nib_q, nib_q};
    lo_stb_d    = stb_q && (state_q == S_LO);
    rs_bad_d    = lo_stb_d && (rs_s_q != hi_rs_q);
    exec_d      = lo_stb_d && !rs_bad_d;
    in_ddram_d  = (addr_q[6:4] == 3'b000) || (addr_q[6:4] == 3'b100);
    wr_idx_d    = {addr_q[6], addr_q[3:0]};
    data_wr_d   = exec_d && rs_s_q && !cgram_q && in_ddram_d;
    addr_step_d = step_addr(addr_q, incr_q);
  end

  always_ff @(posedge clk) begin
    if (clr_common) begin
      state_q     <= S_8BIT;
      hi_nib_q    <= 4'h0;
      hi_rs_q     <= 1'b0;
      addr_q      <= 7'h00;
      cgram_q     <= 1'b0;
      mode_4bit_q <= 1'b0;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      incr_q      <= 1'b1;
      busy_q      <= 1'b1;
      fill_idx_q  <= 5'd0;
      err_q       <= 3'b000;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
      char_wr_q   <= 1'b0;
      char_idx_q  <= 5'd0;
      char_data_q <= 8'h00;
    end else begin
      cmd_valid_q <= 1'b0;
      char_wr_q   <= 1'b0;
      err_q       <= err_q | {ovr_q, rs_bad_d, glitch_q};
      if (busy_q) begin
        fill_idx_q <= fill_idx_q + 5'd1;
        if (fill_idx_q == 5'd31) busy_q <= 1'b0;
      end
      if (stb_q) begin
        case (state_q)
          S_8BIT: begin
            if (nib_q == 4'h2) begin
              state_q     <= S_HI;
              mode_4bit_q <= 1'b1;
            end
          end
          S_HI: begin
            hi_nib_q <= nib_q;
            hi_rs_q  <= rs_s_q;
            state_q  <= S_LO;
          end
          S_LO: begin
            state_q <= S_HI;
            if (exec_d && !rs_s_q) begin
              cmd_valid_q <= 1'b1;
              cmd_byte_q  <= byte_d;
              if (byte_d[7]) begin
                addr_q  <= byte_d[6:0];
                cgram_q <= 1'b0;
              end else if (byte_d[6]) begin
                cgram_q <= 1'b1;
              end else if (byte_d[5]) begin
                if (byte_d[4]) begin
                  state_q     <= S_8BIT;
                  mode_4bit_q <= 1'b0;
                end
              end else if (byte_d[4]) begin
                cgram_q <= cgram_q;
              end else if (byte_d[3]) begin
                {disp_on_q, cursor_on_q, blink_on_q} <= byte_d[2:0];
              end else if (byte_d[2]) begin
                incr_q <= byte_d[1];
              end else if (byte_d[1]) begin
                addr_q  <= 7'h00;
                cgram_q <= 1'b0;
              end else if (byte_d[0]) begin
                addr_q     <= 7'h00;
                cgram_q    <= 1'b0;
                incr_q     <= 1'b1;
                busy_q     <= 1'b1;
                fill_idx_q <= 5'd0;
              end
            end else if (exec_d && !cgram_q) begin
              addr_q <= addr_step_d;
              if (in_ddram_d) begin
                char_wr_q   <= 1'b1;
                char_idx_q  <= wr_idx_d;
                char_data_q <= byte_d;
              end
            end
          end
          default: state_q <= S_8BIT;
        endcase
      end
    end
  end

  // Fill and data writes never coincide: strobes are dropped while the fill runs.
  always_ff @(posedge clk) begin
    if (busy_q)         shadow_mem[fill_idx_q] <= BLANK_CHAR;
    else if (data_wr_d) shadow_mem[wr_idx_d]   <= byte_d;
  end

  always_ff @(posedge clk) begin
    if (clr_common) rd_char_q <= 8'h00;
    else            rd_char_q <= shadow_mem[rd_idx];
  end

  assign rd_char    = rd_char_q;
  assign char_wr    = char_wr_q;
  assign char_idx   = char_idx_q;
  assign char_data  = char_data_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_byte   = cmd_byte_q;
  assign ddram_addr = addr_q;
  assign mode_4bit  = mode_4bit_q;
  assign disp_on    = disp_on_q;
  assign cursor_on  = cursor_on_q;
  assign blink_on   = blink_on_q;
  assign incr       = incr_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: drives the 4-bit LCD bus and checks decoded state and shadow.
module tb_lcd_bus_decoder;
  logic       clk = 1'b0;
  logic       clr_common;
  logic [4:0] rd_idx;
  logic [7:0] rd_char;
  logic       char_wr;
  logic [4:0] char_idx;
  logic [7:0] char_data;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic [6:0] ddram_addr;
  logic       mode_4bit, disp_on, cursor_on, blink_on, incr, busy;
  logic [2:0] err;

  lcd_bus_if bus_if ();

  lcd_bus_decoder #(.MIN_E_HIGH(12), .BLANK_CHAR(8'h20)) dut (
    .clk       (clk),
    .clr_common(clr_common),
    .bus       (bus_if),
    .rd_idx    (rd_idx),
    .rd_char   (rd_char),
    .char_wr   (char_wr),
    .char_idx  (char_idx),
    .char_data (char_data),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .ddram_addr(ddram_addr),
    .mode_4bit (mode_4bit),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .incr      (incr),
    .busy      (busy),
    .err       (err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cmd_cnt = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic [4:0] last_idx = 5'd0;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      cmd_cnt++;
      last_cmd = cmd_byte;
    end
    if (char_wr === 1'b1) begin
      wr_cnt++;
      last_idx = char_idx;
      last_data = char_data;
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_nibble(input logic rs_v, input logic rw_v, input logic [3:0] n,
                             input int hi, input int hold);
    @(negedge clk);
    bus_if.rs = rs_v;
    bus_if.rw = rw_v;
    {bus_if.d, bus_if.c, bus_if.b, bus_if.a} = n;
    bus_if.e = 1'b0;
    @(negedge clk);
    bus_if.e = 1'b1;
    repeat (hi) @(negedge clk);
    bus_if.e = 1'b0;
    repeat (hold) @(negedge clk);
    bus_if.rw = 1'b0;
  endtask

  task automatic send_byte(input logic rs_v, input logic [7:0] bv);
    send_nibble(rs_v, 1'b0, bv[7:4], 20, 4);
    send_nibble(rs_v, 1'b0, bv[3:0], 20, 4);
    $display("byte sent: rs=%0d value=%02h addr_after=%02h", rs_v, bv, ddram_addr);
  endtask

  task automatic read_cell(input logic [4:0] idx, output logic [7:0] val);
    rd_idx = idx;
    @(negedge clk);
    val = rd_char;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int w0;
    int c0;
    logic [7:0] v;

    bus_if.sf_e = 1'b1;
    bus_if.e = 1'b0;
    bus_if.rs = 1'b0;
    bus_if.rw = 1'b0;
    {bus_if.d, bus_if.c, bus_if.b, bus_if.a} = 4'h0;
    rd_idx = 5'd0;
    clr_common = 1'b1;
    repeat (3) @(negedge clk);
    clr_common = 1'b0;

    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_incr", {31'd0, incr}, 32'd1);
    check("rst_mode4", {31'd0, mode_4bit}, 32'd0);
    check("rst_addr", {25'd0, ddram_addr}, 32'd0);
    check("rst_err", {29'd0, err}, 32'd0);
    check("rst_dcb", {29'd0, disp_on, cursor_on, blink_on}, 32'd0);
    check("rst_pulses", {30'd0, cmd_valid, char_wr}, 32'd0);
    check("rst_rdchar", {24'd0, rd_char}, 32'd0);
    count_busy(n);
    check("rst_busy_cycles", n, 32);
    read_cell(5'd5, v);
    check("rst_blank_cell5", {24'd0, v}, 32'h20);

    // T1: 8-bit wake-up sequence then function set
    repeat (3) send_nibble(1'b0, 1'b0, 4'h3, 20, 4);
    check("t1_still_8bit", {31'd0, mode_4bit}, 32'd0);
    send_nibble(1'b0, 1'b0, 4'h2, 20, 4);
    check("t1_mode4", {31'd0, mode_4bit}, 32'd1);
    check("t1_no_cmd", cmd_cnt, 0);
    send_byte(1'b0, 8'h28);
    check("t1_cmd_cnt", cmd_cnt, 1);
    check("t1_cmd_byte", {24'd0, last_cmd}, 32'h28);
    check("t1_mode4_kept", {31'd0, mode_4bit}, 32'd1);

    // T2: entry mode, display on, clear, then three characters
    send_byte(1'b0, 8'h06);
    check("t2_incr", {31'd0, incr}, 32'd1);
    send_byte(1'b0, 8'h0C);
    check("t2_dcb", {29'd0, disp_on, cursor_on, blink_on}, 32'b100);
    busy_cnt = 0;
    send_byte(1'b0, 8'h01);
    wait_idle();
    check("t2_clear_busy", busy_cnt, 32);
    check("t2_clear_addr", {25'd0, ddram_addr}, 32'd0);
    w0 = wr_cnt;
    send_byte(1'b1, 8'h41);
    send_byte(1'b1, 8'h3D);
    send_byte(1'b1, 8'h35);
    check("t2_wr_cnt", wr_cnt - w0, 3);
    check("t2_addr", {25'd0, ddram_addr}, 32'h03);
    read_cell(5'd0, v);
    check("t2_cell0", {24'd0, v}, 32'h41);
    read_cell(5'd1, v);
    check("t2_cell1", {24'd0, v}, 32'h3D);
    read_cell(5'd2, v);
    check("t2_cell2", {24'd0, v}, 32'h35);

    // T3: second line
    send_byte(1'b0, 8'hC0);
    send_byte(1'b1, 8'h37);
    check("t3_idx", {27'd0, last_idx}, 32'd16);
    check("t3_data", {24'd0, last_data}, 32'h37);
    check("t3_addr", {25'd0, ddram_addr}, 32'h41);
    read_cell(5'd16, v);
    check("t3_cell16", {24'd0, v}, 32'h37);

    // T4: off-screen write and address wrap both directions
    w0 = wr_cnt;
    send_byte(1'b0, 8'hA7);
    check("t4_addr27", {25'd0, ddram_addr}, 32'h27);
    send_byte(1'b1, 8'h78);
    check("t4_no_wr", wr_cnt, w0);
    check("t4_wrap_inc", {25'd0, ddram_addr}, 32'h40);
    send_byte(1'b0, 8'h04);
    check("t4_decr", {31'd0, incr}, 32'd0);
    send_byte(1'b0, 8'h80);
    send_byte(1'b1, 8'h79);
    check("t4_wrap_dec", {25'd0, ddram_addr}, 32'h67);
    check("t4_dec_idx", {27'd0, last_idx}, 32'd0);
    check("t4_dec_data", {24'd0, last_data}, 32'h79);

    // T5: short strobe and read strobe leave the nibble phase untouched
    c0 = cmd_cnt;
    send_nibble(1'b0, 1'b0, 4'h0, 5, 4);
    check("t5_glitch", {29'd0, err}, 32'b001);
    check("t5_addr_kept", {25'd0, ddram_addr}, 32'h67);
    send_nibble(1'b0, 1'b1, 4'h0, 20, 4);
    check("t5_read_ignored", {29'd0, err}, 32'b001);
    check("t5_no_cmd", cmd_cnt, c0);
    send_byte(1'b0, 8'h06);
    check("t5_aligned_incr", {31'd0, incr}, 32'd1);
    check("t5_aligned_cmd", cmd_cnt, c0 + 1);

    // T6: rs mismatch, then reset in the middle of a clear fill
    w0 = wr_cnt;
    c0 = cmd_cnt;
    send_nibble(1'b1, 1'b0, 4'h4, 20, 4);
    send_nibble(1'b0, 1'b0, 4'h1, 20, 4);
    check("t6_rs_mismatch", {29'd0, err}, 32'b011);
    check("t6_no_wr", wr_cnt, w0);
    check("t6_no_cmd", cmd_cnt, c0);
    check("t6_not_busy", {31'd0, busy}, 32'd0);
    send_byte(1'b0, 8'h01);
    repeat (10) @(negedge clk);
    check("t6_mid_fill", {31'd0, busy}, 32'd1);
    clr_common = 1'b1;
    @(negedge clk);
    clr_common = 1'b0;
    count_busy(n);
    check("t6_refill_cycles", n, 32);
    check("t6_err_cleared", {29'd0, err}, 32'd0);
    check("t6_mode_reset", {31'd0, mode_4bit}, 32'd0);
    read_cell(5'd0, v);
    check("t6_cell0_blank", {24'd0, v}, 32'h20);

    // Overrun during the reset fill and the minimum-width strobe boundary
    clr_common = 1'b1;
    @(negedge clk);
    clr_common = 1'b0;
    send_nibble(1'b0, 1'b0, 4'h2, 12, 4);
    check("ovr_err", {29'd0, err}, 32'b100);
    check("ovr_dropped", {31'd0, mode_4bit}, 32'd0);
    wait_idle();
    send_nibble(1'b0, 1'b0, 4'h2, 11, 4);
    check("e11_glitch", {29'd0, err}, 32'b101);
    check("e11_dropped", {31'd0, mode_4bit}, 32'd0);
    send_nibble(1'b0, 1'b0, 4'h2, 12, 4);
    check("e12_accepted", {31'd0, mode_4bit}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
